// File: rtl/sub_pkg.sv
// Shared constants and FSM state type for the nibble-serial subtractor.
package sub_pkg;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NDIG);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// One-digit ripple slice: d = a + b + cin, with the carry out of the top bit.
module nibble_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] d,
    output logic         cout
);

    logic [W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign d    = sum[W-1:0];
    assign cout = sum[W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial subtractor Z = X - Y, least significant digit first, with flags.
// Define NIBBLE_SUB_ADD_OP_EN to add an 'op' port selecting add (1) or subtract (0).
module nibble_serial_subtractor #(
    parameter int WIDTH = sub_pkg::WIDTH,
    parameter int DIGIT = sub_pkg::DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef NIBBLE_SUB_ADD_OP_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             borrow,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);

    import sub_pkg::*;

    localparam int NUM_DIG = WIDTH / DIGIT;
    localparam int CW      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int MSB     = WIDTH - 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NUM_DIG - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
        $error("WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             add_r;
    logic             op_in;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [DIGIT-1:0] xd;
    logic [DIGIT-1:0] yd;
    logic [DIGIT-1:0] bd;
    logic [DIGIT-1:0] dd;
    logic             cout;
    logic [WIDTH-1:0] z_next;
    logic             ovf_next;

`ifdef NIBBLE_SUB_ADD_OP_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    // Subtraction is x + ~y + 1: the slice always adds, the inversion lives here.
    always_comb begin
        xd = xr[int'(cnt) * DIGIT +: DIGIT];
        yd = yr[int'(cnt) * DIGIT +: DIGIT];
        bd = add_r ? yd : ~yd;
    end

    nibble_sub_slice #(
        .W(DIGIT)
    ) u_slice (
        .a   (xd),
        .b   (bd),
        .cin (carry),
        .d   (dd),
        .cout(cout)
    );

    // Full result including the digit being produced this cycle, so the flags
    // can be registered on the same edge as the last digit.
    always_comb begin
        z_next = z;
        z_next[int'(cnt) * DIGIT +: DIGIT] = dd;
        if (add_r) begin
            ovf_next = (xr[MSB] == yr[MSB]) && (z_next[MSB] != xr[MSB]);
        end else begin
            ovf_next = (xr[MSB] != yr[MSB]) && (z_next[MSB] != xr[MSB]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xr        <= '0;
            yr        <= '0;
            add_r     <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            z         <= '0;
            borrow    <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            parity    <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xr       <= x;
                        yr       <= y;
                        add_r    <= op_in;
                        carry    <= ~op_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    z     <= z_next;
                    carry <= cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_DIG) begin
                        borrow    <= add_r ? cout : ~cout;
                        sign      <= z_next[MSB];
                        zero      <= ~|z_next;
                        parity    <= ~^z_next;
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake: no same-cycle restart.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
